id_ex_hazard_stall_ctrl: RTL and testbench

- Producer-side controller for the ID/EX pipeline registers. It decides, every cycle, whether the ID/EX stage registers load new decode control, load a bubble (all control zero), or hold their contents.
- It also gates PC and IF/ID writes to match.
- It detects load-use hazards, stretches multi-cycle EX operations (mult/div), and honours taken-branch flushes from EX/MEM.
- It keeps a saturating stall-cycle counter for performance debug.

---
 rtl/id_ex_hazard_stall_ctrl.sv | 125 ++++++++++++
 tb/tb_id_ex_hazard_stall_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_stall_ctrl.sv
// ID/EX producer-side hazard controller: load-use bubbles, multi-cycle EX holds,
// downstream flushes, and a saturating stall-cycle counter for perf debug.
module id_ex_hazard_stall_ctrl #(
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned REG_W    = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mult_start,
  input  logic             mem_flush,
  input  logic             stat_clear,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_hold,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic {
    RUN,
    MULT_BUSY
  } state_t;

  localparam bit         MULTI    = (MULT_LAT > 1);
  localparam logic [3:0] CNT_INIT = 4'(MULT_LAT - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic load_use;
  logic hold;

  assign load_use = id_valid & ex_mem_read & ex_reg_write & (ex_rd != '0) &
                    ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

  // The final EX cycle of a multi-cycle op (cnt==1) is not held.
  assign hold = ((state_q == RUN) & ex_mult_start & MULTI) |
                ((state_q == MULT_BUSY) & (cnt_q > 4'd1));

  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    ex_hold        = 1'b0;
    if (!reset_n) begin
      id_ex_bubble = 1'b1;
    end else if (mem_flush) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (hold) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      ex_hold        = 1'b1;
    end else if (load_use) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_bubble   = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (mem_flush) begin
      state_d = RUN;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (ex_mult_start && MULTI) begin
            state_d = MULT_BUSY;
            cnt_d   = CNT_INIT;
          end
        end
        MULT_BUSY: begin
          if (cnt_q > 4'd1) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stat_clear) begin
      stall_count_d = '0;
    end else if (!pc_write_en && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_id_ex_hazard_stall_ctrl.sv
// Directed bench for id_ex_hazard_stall_ctrl (MULT_LAT=4, CNT_W=16).
module tb_id_ex_hazard_stall_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       id_valid, id_uses_rt, ex_mem_read, ex_reg_write;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       ex_mult_start, mem_flush, stat_clear;
  logic       pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_hold;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  // {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_hold}
  localparam logic [4:0] O_RUN   = 5'b11000;
  localparam logic [4:0] O_LU    = 5'b00010;
  localparam logic [4:0] O_HOLD  = 5'b00001;
  localparam logic [4:0] O_FLUSH = 5'b11110;
  localparam logic [4:0] O_RST   = 5'b11010;

  id_ex_hazard_stall_ctrl #(
    .MULT_LAT(4),
    .CNT_W   (16),
    .REG_W   (5)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .ex_mem_read   (ex_mem_read),
    .ex_reg_write  (ex_reg_write),
    .ex_rd         (ex_rd),
    .ex_mult_start (ex_mult_start),
    .mem_flush     (mem_flush),
    .stat_clear    (stat_clear),
    .pc_write_en   (pc_write_en),
    .if_id_write_en(if_id_write_en),
    .if_id_flush   (if_id_flush),
    .id_ex_bubble  (id_ex_bubble),
    .ex_hold       (ex_hold),
    .stall_count   (stall_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic chk_out(input string tag, input logic [4:0] exp);
    @(negedge clock);
    chk(tag, {27'd0, pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_hold},
        {27'd0, exp});
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] exp);
    @(negedge clock);
    chk(tag, {16'd0, stall_count}, {16'd0, exp});
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_uses_rt = 0; ex_mem_read = 0; ex_reg_write = 0;
    id_rs = 0; id_rt = 0; ex_rd = 0;
    ex_mult_start = 0; mem_flush = 0; stat_clear = 0;
  endtask

  task automatic set_load_use_rs8();
    id_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd8; id_rs = 5'd8;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    #2;
    chk("rst_out", {27'd0, pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_hold},
        {27'd0, O_RST});
    chk("rst_cnt", {16'd0, stall_count}, 32'd0);
    advance();
    reset_n = 1'b1;
    chk_out("run_idle", O_RUN);
    advance();

    // load-use on rs: one bubble, then release
    set_load_use_rs8();
    chk_out("lu_rs", O_LU);
    advance();
    ex_mem_read = 0;
    chk_out("lu_release", O_RUN);
    chk_cnt("lu_cnt", 16'd1);
    stat_clear = 1;
    advance();
    idle();
    chk_cnt("clr_cnt", 16'd0);

    // no false stalls
    id_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_rd = 0; id_rs = 0;
    chk_out("nofs_r0", O_RUN);
    advance();
    ex_rd = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 0;
    chk_out("nofs_nort", O_RUN);
    advance();
    id_uses_rt = 1; id_valid = 0;
    chk_out("nofs_invalid", O_RUN);
    advance();
    chk_cnt("nofs_cnt", 16'd0);
    id_valid = 1;
    chk_out("lu_rt", O_LU);
    advance();
    idle();
    stat_clear = 1;
    advance();
    stat_clear = 0;

    // multi-cycle op: 3 hold cycles starting in the pulse cycle
    ex_mult_start = 1;
    chk_out("mult_h1", O_HOLD);
    advance();
    ex_mult_start = 0;
    chk_out("mult_h2", O_HOLD);
    advance();
    ex_mult_start = 1;
    chk_out("mult_h3_ign", O_HOLD);
    advance();
    ex_mult_start = 0;
    chk_out("mult_last", O_RUN);
    chk_cnt("mult_cnt", 16'd3);
    advance();
    chk_out("mult_after", O_RUN);
    stat_clear = 1;
    advance();
    stat_clear = 0;

    // flush in the 2nd hold cycle aborts the op
    ex_mult_start = 1;
    chk_out("fm_h1", O_HOLD);
    advance();
    ex_mult_start = 0; mem_flush = 1;
    chk_out("fm_flush", O_FLUSH);
    advance();
    mem_flush = 0;
    chk_out("fm_run", O_RUN);
    advance();

    // hold beats load-use
    set_load_use_rs8();
    ex_mult_start = 1;
    chk_out("hold_vs_lu", O_HOLD);
    advance();
    idle();
    chk_out("hvl_h2", O_HOLD);
    advance();
    chk_out("hvl_h3", O_HOLD);
    advance();
    chk_out("hvl_done", O_RUN);
    advance();

    // flush beats load-use
    set_load_use_rs8();
    mem_flush = 1;
    chk_out("flush_vs_lu", O_FLUSH);
    advance();
    idle();

    // async reset mid-MULT_BUSY
    ex_mult_start = 1;
    advance();
    ex_mult_start = 0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_out", {27'd0, pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_hold},
        {27'd0, O_RST});
    chk("async_rst_cnt", {16'd0, stall_count}, 32'd0);
    advance();
    reset_n = 1'b1;
    chk_out("post_rst_run", O_RUN);
    advance();

    // saturation of stall_count
    set_load_use_rs8();
    repeat (65540) advance();
    chk_cnt("sat_cnt", 16'hFFFF);
    chk_out("sat_out", O_LU);
    advance();
    stat_clear = 1;
    advance();
    stat_clear = 0;
    chk_cnt("sat_clr", 16'd0);
    advance();
    chk_cnt("post_clr_inc", 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
